// File: rtl/brisc_pkg.sv
// Shared core types: data width, access size and the store-buffer entry layout.
package brisc_pkg;

  localparam int XLEN            = 32;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int STB_NUM_ENTRIES = 4;

  typedef enum logic {
    SIZE_W = 1'b0,
    SIZE_B = 1'b1
  } data_size_e;

  typedef struct packed {
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [XLEN-1:0]          data;
    data_size_e               size;
  } stb_entry_t;

  // Little-endian byte lane `sel` of a word, zero-extended to XLEN.
  function automatic logic [XLEN-1:0] zext_byte(input logic [XLEN-1:0] word,
                                                input logic [1:0]      sel);
    return {{(XLEN-8){1'b0}}, word[{sel, 3'b000} +: 8]};
  endfunction

endpackage

// File: rtl/stb_forward_unit.sv
// Store-to-load forwarding: youngest-first priority search over the buffered stores.
module stb_forward_unit
  import brisc_pkg::*;
#(
  parameter int NUM_ENTRIES = STB_NUM_ENTRIES,
  parameter int ADDR_WIDTH  = ADDRESS_WIDTH,
  localparam int PTR_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                  i_is_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  data_size_e            i_data_size,
  input  stb_entry_t            i_entries [NUM_ENTRIES],
  input  logic [PTR_W-1:0]      i_tail_ptr,
  output logic [XLEN-1:0]       o_read_data,
  output logic                  o_read_valid,
  output logic                  o_load_stall
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  stb_entry_t       w_e;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    o_read_data  = '0;
    o_read_valid = 1'b0;
    o_load_stall = 1'b0;
    w_found      = 1'b0;
    w_idx        = '0;
    w_e          = '0;
    // k=1 is the youngest entry (tail-1); k=NUM_ENTRIES wraps to the oldest slot.
    for (int k = 1; k <= NUM_ENTRIES; k++) begin
      w_idx = i_tail_ptr - PTR_W'(k);
      w_e   = i_entries[w_idx];
      if (i_is_load && !w_found && w_e.valid &&
          (w_e.addr[ADDR_WIDTH-1:2] == i_addr[ADDR_WIDTH-1:2])) begin
        if (w_e.size == SIZE_W) begin
          w_found      = 1'b1;
          o_read_valid = 1'b1;
          o_read_data  = (i_data_size == SIZE_W) ? w_e.data : zext_byte(w_e.data, i_addr[1:0]);
        end else if (i_data_size == SIZE_W) begin
          // A byte store only partly covers a word load: wait for it to drain.
          w_found      = 1'b1;
          o_load_stall = 1'b1;
        end else if (w_e.addr[1:0] == i_addr[1:0]) begin
          w_found      = 1'b1;
          o_read_valid = 1'b1;
          o_read_data  = w_e.data;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between MEM and the data cache, with head drain and load forwarding.
module store_buffer
  import brisc_pkg::*;
#(
  parameter int NUM_ENTRIES = STB_NUM_ENTRIES,
  parameter int ADDR_WIDTH  = ADDRESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_store,
  input  logic                  is_load,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  data_size_e            data_size,
  input  logic [XLEN-1:0]       store_data,
  output logic [XLEN-1:0]       stb_read_data,
  output logic                  stb_read_valid,
  output logic                  stb_load_stall,
  output logic                  stb_full_stall,
  output logic                  stb_write,
  input  logic                  stb_write_ready,
  output logic [ADDR_WIDTH-1:0] stb_write_addr,
  output logic [XLEN-1:0]       stb_write_data,
  output data_size_e            stb_write_size
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [ADDR_WIDTH-1:0]  r_addr [NUM_ENTRIES];
  logic [XLEN-1:0]        r_data [NUM_ENTRIES];
  data_size_e             r_size [NUM_ENTRIES];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  stb_entry_t w_entries [NUM_ENTRIES];
  logic       w_full;
  logic       w_push;
  logic       w_pop;

  assign w_full         = (r_count == CNT_W'(NUM_ENTRIES));
  assign w_pop          = stb_write & stb_write_ready;
  assign stb_full_stall = is_store & w_full & ~w_pop;
  assign w_push         = is_store & ~stb_full_stall;

  assign stb_write      = r_valid[r_head];
  assign stb_write_addr = stb_write ? r_addr[r_head] : '0;
  assign stb_write_data = stb_write ? r_data[r_head] : '0;
  assign stb_write_size = stb_write ? r_size[r_head] : SIZE_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Pop first so a push into the slot being freed (full, push+pop) keeps it valid.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: payload storage is not reset; every consumer qualifies it with r_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= addr;
      r_data[r_tail] <= (data_size == SIZE_B) ? zext_byte(store_data, 2'b00) : store_data;
      r_size[r_tail] <= data_size;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_entries[i] = '{valid: r_valid[i], addr: r_addr[i], data: r_data[i], size: r_size[i]};
    end
  end

  stb_forward_unit #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_forward (
    .i_is_load   (is_load),
    .i_addr      (addr),
    .i_data_size (data_size),
    .i_entries   (w_entries),
    .i_tail_ptr  (r_tail),
    .o_read_data (stb_read_data),
    .o_read_valid(stb_read_valid),
    .o_load_stall(stb_load_stall)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: byte-coverage reference model, directed scenarios, random traffic.
module tb_store_buffer;
  import brisc_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_store, is_load, stb_write_ready;
  logic [31:0] addr, store_data;
  data_size_e  data_size;
  logic [31:0] stb_read_data, stb_write_addr, stb_write_data;
  logic        stb_read_valid, stb_load_stall, stb_full_stall, stb_write;
  data_size_e  stb_write_size;

  store_buffer #(.NUM_ENTRIES(N), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .is_store(is_store), .is_load(is_load), .addr(addr),
    .data_size(data_size), .store_data(store_data), .stb_read_data(stb_read_data),
    .stb_read_valid(stb_read_valid), .stb_load_stall(stb_load_stall),
    .stb_full_stall(stb_full_stall), .stb_write(stb_write), .stb_write_ready(stb_write_ready),
    .stb_write_addr(stb_write_addr), .stb_write_data(stb_write_data),
    .stb_write_size(stb_write_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    data_size_e  size;
  } m_entry_t;

  typedef struct {
    logic        write;
    m_entry_t    head;
    logic        full_stall;
    logic        read_valid;
    logic [31:0] read_data;
    logic        load_stall;
  } exp_t;

  m_entry_t model_q[$];
  exp_t     exp_cyc[$];
  m_entry_t exp_drain[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference forwarding: youngest store whose written bytes intersect the load's bytes decides.
  function automatic void model_load(input logic ld, input logic [31:0] a, input data_size_e sz,
                                     output logic v, output logic [31:0] d, output logic st);
    logic [3:0] need, have;
    v = 1'b0; d = '0; st = 1'b0;
    if (!ld) return;
    need = (sz == SIZE_W) ? 4'hF : (4'b0001 << a[1:0]);
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].addr[31:2] != a[31:2]) continue;
      have = (model_q[i].size == SIZE_W) ? 4'hF : (4'b0001 << model_q[i].addr[1:0]);
      if ((have & need) == 4'h0) continue;
      if ((have & need) == need) begin
        v = 1'b1;
        if (model_q[i].size == SIZE_B)  d = model_q[i].data & 32'hFF;
        else if (sz == SIZE_W)          d = model_q[i].data;
        else                            d = (model_q[i].data >> (8 * a[1:0])) & 32'hFF;
      end else begin
        st = 1'b1;
      end
      return;
    end
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model at the edge.
  task automatic cycle(input logic st, input logic ld, input logic [31:0] a, input data_size_e sz,
                       input logic [31:0] sd, input logic rdy);
    exp_t     e;
    m_entry_t ne;
    logic     pop, full, push;
    is_store = st; is_load = ld; addr = a; data_size = sz; store_data = sd;
    stb_write_ready = rdy;
    pop  = (model_q.size() > 0) && rdy;
    full = st && (model_q.size() == N) && !pop;
    push = st && !full;
    e.write = (model_q.size() > 0);
    e.head  = e.write ? model_q[0] : '{addr: 32'h0, data: 32'h0, size: SIZE_W};
    e.full_stall = full;
    model_load(ld, a, sz, e.read_valid, e.read_data, e.load_stall);
    exp_cyc.push_back(e);
    if (pop) exp_drain.push_back(model_q[0]);
    ne = '{addr: a, data: (sz == SIZE_B) ? (sd & 32'hFF) : sd, size: sz};
    @(posedge clk);
    if (pop)  void'(model_q.pop_front());
    if (push) model_q.push_back(ne);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 32'h0, SIZE_W, 32'h0, rdy);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    is_store = 1'b0; is_load = 1'b0; stb_write_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_write", stb_write, 32'h0);
    check("rst_write_addr", stb_write_addr, 32'h0);
    check("rst_write_data", stb_write_data, 32'h0);
    check("rst_write_size", stb_write_size, SIZE_W);
    check("rst_full_stall", stb_full_stall, 32'h0);
    model_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  exp_t     mon_e;
  m_entry_t mon_d;

  always @(negedge clk) begin
    if (!reset && exp_cyc.size() > 0) begin
      mon_e = exp_cyc.pop_front();
      check("stb_write", stb_write, mon_e.write);
      check("head_addr", stb_write_addr, mon_e.head.addr);
      check("head_data", stb_write_data, mon_e.head.data);
      check("head_size", stb_write_size, mon_e.head.size);
      check("full_stall", stb_full_stall, mon_e.full_stall);
      check("read_valid", stb_read_valid, mon_e.read_valid);
      check("read_data", stb_read_data, mon_e.read_data);
      check("load_stall", stb_load_stall, mon_e.load_stall);
    end
    if (!reset && stb_write && stb_write_ready) begin
      if (exp_drain.size() == 0) begin
        check("unexpected_drain", 32'h1, 32'h0);
      end else begin
        mon_d = exp_drain.pop_front();
        check("drain_addr", stb_write_addr, mon_d.addr);
        check("drain_data", stb_write_data, mon_d.data);
        check("drain_size", stb_write_size, mon_d.size);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    int          r;
    reset = 1'b1; is_store = 1'b0; is_load = 1'b0; addr = '0;
    data_size = SIZE_W; store_data = '0; stb_write_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_write", stb_write, 32'h0);
    check("init_write_data", stb_write_data, 32'h0);
    check("init_read_valid", stb_read_valid, 32'h0);
    reset = 1'b0;

    // Reset while draining
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h40 + 4 * i, SIZE_W, 32'h1000 + i, 1'b0);
    idle(1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h80 + 4 * i, SIZE_W, 32'h2000 + i, 1'b0);
    // Full: fifth store stalls, then succeeds with a simultaneous pop
    cycle(1'b1, 1'b0, 32'h90, SIZE_W, 32'h2004, 1'b0);
    cycle(1'b1, 1'b0, 32'h90, SIZE_W, 32'h2004, 1'b1);
    cycle(1'b1, 1'b0, 32'h94, SIZE_W, 32'h2005, 1'b0);
    repeat (6) idle(1'b1);

    // Drain order
    cycle(1'b1, 1'b0, 32'h100, SIZE_W, 32'hAABBCCDD, 1'b0);
    cycle(1'b1, 1'b0, 32'h204, SIZE_B, 32'hFFFF_FF11, 1'b0);
    repeat (3) idle(1'b1);

    // Word store forwarded to a byte load
    cycle(1'b1, 1'b0, 32'h100, SIZE_W, 32'hAABBCCDD, 1'b0);
    cycle(1'b0, 1'b1, 32'h102, SIZE_B, 32'h0, 1'b0);
    // Youngest wins, then a miss
    cycle(1'b1, 1'b0, 32'h100, SIZE_W, 32'h1, 1'b0);
    cycle(1'b1, 1'b0, 32'h100, SIZE_W, 32'h2, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, SIZE_W, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h300, SIZE_W, 32'h0, 1'b0);
    repeat (4) idle(1'b1);

    // Partial coverage stalls until the byte store drains (popped entry still visible)
    cycle(1'b1, 1'b0, 32'h101, SIZE_B, 32'h55, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, SIZE_W, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, SIZE_W, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, SIZE_W, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h100, SIZE_W, 32'h0, 1'b0);

    // Random traffic: slow drain first (exercises full), then fast drain
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 200; c++) begin
        r = $urandom_range(0, 9);
        case ($urandom_range(0, 2))
          0:       base = 32'h100;
          1:       base = 32'h104;
          default: base = 32'h300;
        endcase
        base = base + $urandom_range(0, 3);
        cycle(r < 4, (r >= 4) && (r < 7), base,
              ($urandom_range(0, 1) == 0) ? SIZE_W : SIZE_B, $urandom,
              (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end
      if (phase == 0) do_reset();
    end
    repeat (6) idle(1'b1);

    @(negedge clk);
    #1;
    check("pending_cycle_checks", exp_cyc.size(), 32'h0);
    check("pending_drains", exp_drain.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
